reg_bank_param: RTL
===================

REG_BANK_PARAM -- requirements
Module: reg_bank_param

Interface
REQ-001 SHALL: parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL: parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL: parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and ignores writes.
REQ-004 SHALL: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL: rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL: rs  input  ADDR_W  read address, port A.
REQ-007 SHALL: rt  input  ADDR_W  read address, port B.
REQ-008 SHALL: rd  input  ADDR_W  write address.
REQ-009 SHALL: write_data  input  DATA_W  write data.
REQ-010 SHALL: reg_write  input  1  write enable.
REQ-011 SHALL: A  output  DATA_W  read data, port A.
REQ-012 SHALL: B  output  DATA_W  read data, port B.
REQ-013 SHALL: ready  output  1  high once clear sweep is done and the bank accepts accesses.

Function
REQ-014 SHALL: two-state FSM, CLEAR and READY; rst forces CLEAR with sweep pointer ptr = 0.
REQ-015 SHALL: in CLEAR, each rising edge writes 0 to entry ptr and increments ptr; on the edge that clears entry DEPTH-1, FSM moves to READY and ptr wraps to 0.
REQ-016 SHALL: clear sweep take exactly DEPTH rising edges after rst deasserts; ready rises on the DEPTH-th edge.
REQ-017 SHALL: in CLEAR, ignore reg_write and drive A = B = 0.
REQ-018 SHALL: in READY, when reg_write = 1, write write_data to entry rd on the rising edge, one write per cycle.
REQ-019 SHALL: when ZERO_REG = 1 and rd = 0, drop the write, leaving state unchanged.
REQ-020 SHALL: in READY, reads be combinational, zero latency: A = entry[rs], B = entry[rt], both ports independent; rs = rt allowed.
REQ-021 SHALL: when ZERO_REG = 1, A (B) be 0 whenever rs (rt) = 0, regardless of stored contents.
REQ-022 SHALL: without bypass, a read of the address being written in the same cycle return the old value; the new value is visible the cycle after the edge.
REQ-023 SHALL: the FSM have no path from READY back to CLEAR other than rst.

Reset
REQ-024 SHALL: rst asserted at any time, including mid-sweep or mid-write, immediately force ready = 0, A = B = 0, FSM = CLEAR, ptr = 0.
REQ-025 SHALL: any write coincident with rst asserted be discarded; a full sweep restarts after deassertion.

Configuration
REQ-026 SHALL: macro REGFILE_BYPASS_EN, when defined, make A = write_data when ready, reg_write = 1, rd = rs, and the write is not dropped by REQ-019; likewise B for rt.
REQ-027 SHALL: without REGFILE_BYPASS_EN, reads follow REQ-022 (no forwarding); all other behaviour is identical in both builds.

Verification
REQ-028 SHALL: defaults; pulse rst, hold reg_write = 1 to rd = 3 during sweep -> ready low exactly 32 edges, A = B = 0 throughout, entry 3 reads 0 after ready.
REQ-029 SHALL: READY; write 0x964EB to rd = 5, then rs = 5, rt = 5 next cycle -> A = B = 0x964EB.
REQ-030 SHALL: ZERO_REG = 1; write 0xDEADBEEF to rd = 0 -> rs = 0 reads 0; ZERO_REG = 0 build -> reads 0xDEADBEEF.
REQ-031 SHALL: rs = rd = 7, write 0x113D4 over old 0x6 in the same cycle -> A = 0x113D4 with REGFILE_BYPASS_EN, A = 0x6 without it until after the edge.
REQ-032 SHALL: assert rst at sweep ptr = 10 -> ready stays 0; after release, exactly DEPTH further edges until ready = 1.
REQ-033 SHALL: DATA_W = 16, ADDR_W = 3; write 0xFFFF to entry 7, then back-to-back writes to entries 0..7 -> 8-edge sweep, all eight values read back correctly, entry 0 = 0.

Source files
------------

// File: rtl/reg_bank_param_if.sv
// reg_bank_param_if: register bank access bus (two read ports, one write port, ready)
interface reg_bank_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0] write_data, A, B;
  logic reg_write, ready;
  modport master(output rs, rt, rd, write_data, reg_write, input A, B, ready);
  modport slave(input rs, rt, rd, write_data, reg_write, output A, B, ready);
endinterface

// File: rtl/reg_bank_param.sv
// reg_bank_param: 2R1W register bank with post-reset clear sweep; define REGFILE_BYPASS_EN for write-to-read forwarding
module reg_bank_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst,
  reg_bank_param_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
`ifdef REGFILE_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n, wa;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wd;
  logic we, wr_ok, fwd_a, fwd_b, zero_a, zero_b, rdy;
  // FSM state and sweep pointer; READY is only left through rst
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLEAR;
      ptr <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
    end
  // Storage: the sweep clears one entry per edge, then accepted user writes land; nothing lands while rst is high
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // Next state, write port muxing and combinational read ports
  always_comb begin
    rdy = state == READY;
    wr_ok = bus.reg_write && !(ZERO_REG != 0 && bus.rd == '0);
    state_n = (!rdy && &ptr) ? READY : state;
    ptr_n = rdy ? ptr : ptr + 1'b1;
    we = !rst && (!rdy || wr_ok);
    wa = rdy ? bus.rd : ptr;
    wd = rdy ? bus.write_data : '0;
    zero_a = ZERO_REG != 0 && bus.rs == '0;
    zero_b = ZERO_REG != 0 && bus.rt == '0;
    fwd_a = BYPASS && wr_ok && bus.rd == bus.rs;
    fwd_b = BYPASS && wr_ok && bus.rd == bus.rt;
    bus.ready = rdy;
    bus.A = (!rdy || zero_a) ? '0 : fwd_a ? bus.write_data : mem[bus.rs];
    bus.B = (!rdy || zero_b) ? '0 : fwd_b ? bus.write_data : mem[bus.rt];
  end
endmodule
